// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and default bus widths for the ibus/dbus memory arbiter.
package mem_bus_arbiter_pkg;

  localparam int MEM_ADDR_BUS_W = 32;
  localparam int MEM_DATA_BUS_W = 32;
  localparam int DBUS_MASK_W    = MEM_DATA_BUS_W / 8;
  localparam int TCNT_W         = 8;
  localparam int STARVE_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_bus_arbiter_arb_prio_starve.sv
// Two-requester arbiter: dbus wins by default, ibus is forced through after
// MAX_DBURST consecutive dbus grants made while ibus was waiting.
module arb_prio_starve
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_DBURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ibus_req,
  input  logic       dbus_req,
  output logic [1:0] gnt
);

  localparam logic [STARVE_W-1:0] MAXB = STARVE_W'(MAX_DBURST);

  logic [STARVE_W-1:0] starve;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (dbus_req && !(ibus_req && (starve == MAXB))) begin
        gnt[OWN_D] = 1'b1;
      end else if (ibus_req) begin
        gnt[OWN_I] = 1'b1;
      end
    end
  end

  // Counter only moves on IDLE-cycle arbitration decisions
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve <= '0;
    end else if (en) begin
      if (!ibus_req || gnt[OWN_I]) begin
        starve <= '0;
      end else if (gnt[OWN_D] && (starve != MAXB)) begin
        starve <= starve + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Sequences ibus and dbus onto one handshaked memory port: latch the winner,
// hold the request until gnt, then wait for rvalid or a timeout.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int                ADDR_W     = MEM_ADDR_BUS_W,
  parameter int                DATA_W     = MEM_DATA_BUS_W,
  parameter int                MASK_W     = DBUS_MASK_W,
  parameter logic [ADDR_W-1:0] ADDR_MASK  = 32'h7fff_ffff,
  parameter int                MAX_DBURST = 4,
  parameter int                TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_ibus_req,
  input  logic              I_ibus_we,
  input  logic [ADDR_W-1:0] I_ibus_addr,
  input  logic [DATA_W-1:0] I_ibus_wdata,
  input  logic [MASK_W-1:0] I_ibus_mask,
  output logic [DATA_W-1:0] O_ibus_rdata,
  output logic              O_ibus_ready,
  output logic              O_ibus_err,
  input  logic              I_dbus_req,
  input  logic              I_dbus_we,
  input  logic [ADDR_W-1:0] I_dbus_addr,
  input  logic [DATA_W-1:0] I_dbus_wdata,
  input  logic [MASK_W-1:0] I_dbus_mask,
  output logic [DATA_W-1:0] O_dbus_rdata,
  output logic              O_dbus_ready,
  output logic              O_dbus_err,
  output logic              O_mem_req,
  output logic              O_mem_we,
  output logic [ADDR_W-1:0] O_mem_addr,
  output logic [DATA_W-1:0] O_mem_wdata,
  output logic [MASK_W-1:0] O_mem_mask,
  input  logic              I_mem_gnt,
  input  logic              I_mem_rvalid,
  input  logic [DATA_W-1:0] I_mem_rdata
);

  localparam logic [TCNT_W-1:0] TOUT = TCNT_W'(TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  owner_t            owner;
  logic [TCNT_W-1:0] tcnt;
  logic [1:0]        gnt;
  logic              start;
  logic              done;
  logic              tout;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] mask_q;

  arb_prio_starve #(
    .MAX_DBURST(MAX_DBURST)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (state == ST_IDLE),
    .ibus_req(I_ibus_req),
    .dbus_req(I_dbus_req),
    .gnt     (gnt)
  );

  assign start = |gnt;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    tout      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (I_mem_gnt) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A response landing on the timeout cycle still counts as good data
        if (I_mem_rvalid) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else if (tcnt == TOUT) begin
          done      = 1'b1;
          tout      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      owner <= OWN_I;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (start) owner <= gnt[OWN_D] ? OWN_D : OWN_I;
      if (state == ST_REQ) begin
        tcnt <= '0;
      end else if ((state == ST_WAIT) && (tcnt != TOUT)) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  // Request fields are only visible on the port in REQ, so they need no reset
  always_ff @(posedge clk) begin
    if (start) begin
      if (gnt[OWN_D]) begin
        we_q    <= I_dbus_we;
        addr_q  <= I_dbus_addr & ADDR_MASK;
        wdata_q <= I_dbus_wdata;
        mask_q  <= I_dbus_mask;
      end else begin
        we_q    <= I_ibus_we;
        addr_q  <= I_ibus_addr & ADDR_MASK;
        wdata_q <= I_ibus_wdata;
        mask_q  <= I_ibus_mask;
      end
    end
  end

  assign O_mem_req   = (state == ST_REQ);
  assign O_mem_we    = O_mem_req ? we_q    : 1'b0;
  assign O_mem_addr  = O_mem_req ? addr_q  : '0;
  assign O_mem_wdata = O_mem_req ? wdata_q : '0;
  assign O_mem_mask  = O_mem_req ? mask_q  : '0;

  assign O_ibus_ready = done && (owner == OWN_I);
  assign O_ibus_err   = tout && (owner == OWN_I);
  assign O_ibus_rdata = (O_ibus_ready && !tout) ? I_mem_rdata : '0;

  assign O_dbus_ready = done && (owner == OWN_D);
  assign O_dbus_err   = tout && (owner == OWN_D);
  assign O_dbus_rdata = (O_dbus_ready && !tout) ? I_mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: cycle vector table plus hand-written
// burst-order, timeout and mid-transaction reset sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ibus_req, ibus_we, dbus_req, dbus_we;
  logic [31:0] ibus_addr, ibus_wdata, dbus_addr, dbus_wdata;
  logic [3:0]  ibus_mask, dbus_mask;
  logic [31:0] ibus_rdata, dbus_rdata;
  logic        ibus_ready, ibus_err, dbus_ready, dbus_err;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .MAX_DBURST(4),
    .TIMEOUT   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .I_ibus_req  (ibus_req),
    .I_ibus_we   (ibus_we),
    .I_ibus_addr (ibus_addr),
    .I_ibus_wdata(ibus_wdata),
    .I_ibus_mask (ibus_mask),
    .O_ibus_rdata(ibus_rdata),
    .O_ibus_ready(ibus_ready),
    .O_ibus_err  (ibus_err),
    .I_dbus_req  (dbus_req),
    .I_dbus_we   (dbus_we),
    .I_dbus_addr (dbus_addr),
    .I_dbus_wdata(dbus_wdata),
    .I_dbus_mask (dbus_mask),
    .O_dbus_rdata(dbus_rdata),
    .O_dbus_ready(dbus_ready),
    .O_dbus_err  (dbus_err),
    .O_mem_req   (mem_req),
    .O_mem_we    (mem_we),
    .O_mem_addr  (mem_addr),
    .O_mem_wdata (mem_wdata),
    .O_mem_mask  (mem_mask),
    .I_mem_gnt   (mem_gnt),
    .I_mem_rvalid(mem_rvalid),
    .I_mem_rdata (mem_rdata)
  );

  typedef struct {
    logic        ireq, iwe;
    logic [31:0] iaddr, iwdata;
    logic [3:0]  imask;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic [3:0]  dmask;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_mask;
    logic        e_ir, e_ie;
    logic [31:0] e_ird;
    logic        e_dr, e_de;
    logic [31:0] e_drd;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_req, input logic e_we,
                         input logic [31:0] e_addr, input logic [31:0] e_wdata,
                         input logic [3:0] e_mask, input logic e_ir, input logic e_ie,
                         input logic [31:0] e_ird, input logic e_dr, input logic e_de,
                         input logic [31:0] e_drd);
    chk({tag, ".mem_req"},   32'(mem_req),    32'(e_req));
    chk({tag, ".mem_we"},    32'(mem_we),     32'(e_we));
    chk({tag, ".mem_addr"},  mem_addr,        e_addr);
    chk({tag, ".mem_wdata"}, mem_wdata,       e_wdata);
    chk({tag, ".mem_mask"},  32'(mem_mask),   32'(e_mask));
    chk({tag, ".i_ready"},   32'(ibus_ready), 32'(e_ir));
    chk({tag, ".i_err"},     32'(ibus_err),   32'(e_ie));
    chk({tag, ".i_rdata"},   ibus_rdata,      e_ird);
    chk({tag, ".d_ready"},   32'(dbus_ready), 32'(e_dr));
    chk({tag, ".d_err"},     32'(dbus_err),   32'(e_de));
    chk({tag, ".d_rdata"},   dbus_rdata,      e_drd);
  endtask

  task automatic idle_inputs();
    ibus_req = 0; ibus_we = 0; ibus_addr = '0; ibus_wdata = '0; ibus_mask = '0;
    dbus_req = 0; dbus_we = 0; dbus_addr = '0; dbus_wdata = '0; dbus_mask = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_order [10];
    int   got;

    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // ibus read with immediate gnt/rvalid
    tbl[0]  = '{1, 0, 32'h8000_0010, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 32'h8000_0010, 0, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0,
                1, 0, 32'h0000_0010, 0, 4'hF, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 32'h8000_0010, 0, 4'hF, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF,
                0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    // dbus write, gnt delayed 3 cycles, master fields change after grant
    tbl[4]  = '{0, 0, 0, 0, 0, 1, 1, 32'h8000_0100, 32'h1234_5678, 4'b0011, 0, 0, 0,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 1, 1, 32'h8000_0100, 32'h1234_5678, 4'b0011, 0, 0, 0,
                1, 1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, 32'h0000_0ABC, 32'h0, 4'hF, 0, 0, 0,
                1, 1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 1, 32'h8000_0100, 32'h1234_5678, 4'b0011, 0, 0, 0,
                1, 1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 1, 32'h8000_0100, 32'h1234_5678, 4'b0011, 1, 0, 0,
                1, 1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 1, 1, 32'h8000_0100, 32'h1234_5678, 4'b0011, 1, 0, 0,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 1, 32'h8000_0100, 32'h1234_5678, 4'b0011, 0, 1, 32'hCAFE_0000,
                0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hCAFE_0000};
    // stray rvalid in IDLE, then in REQ
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_1111,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{1, 1, 32'hFFFF_FFFC, 32'hA0A0_A0A0, 4'hC, 0, 0, 0, 0, 0, 0, 1, 32'h2222_2222,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{1, 1, 32'hFFFF_FFFC, 32'hA0A0_A0A0, 4'hC, 0, 0, 0, 0, 0, 0, 1, 32'h3333_3333,
                1, 1, 32'h7FFF_FFFC, 32'hA0A0_A0A0, 4'hC, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{1, 1, 32'hFFFF_FFFC, 32'hA0A0_A0A0, 4'hC, 0, 0, 0, 0, 0, 1, 0, 0,
                1, 1, 32'h7FFF_FFFC, 32'hA0A0_A0A0, 4'hC, 0, 0, 0, 0, 0, 0};
    tbl[15] = '{1, 1, 32'hFFFF_FFFC, 32'hA0A0_A0A0, 4'hC, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0005,
                0, 0, 0, 0, 0, 1, 0, 32'h0000_0005, 0, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    for (int i = 0; i < 17; i++) begin
      ibus_req = tbl[i].ireq; ibus_we = tbl[i].iwe; ibus_addr = tbl[i].iaddr;
      ibus_wdata = tbl[i].iwdata; ibus_mask = tbl[i].imask;
      dbus_req = tbl[i].dreq; dbus_we = tbl[i].dwe; dbus_addr = tbl[i].daddr;
      dbus_wdata = tbl[i].dwdata; dbus_mask = tbl[i].dmask;
      mem_gnt = tbl[i].gnt; mem_rvalid = tbl[i].rvalid; mem_rdata = tbl[i].rdata;
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_we, tbl[i].e_addr,
              tbl[i].e_wdata, tbl[i].e_mask, tbl[i].e_ir, tbl[i].e_ie, tbl[i].e_ird,
              tbl[i].e_dr, tbl[i].e_de, tbl[i].e_drd);
      next_cycle();
    end

    // Both masters saturating the port: dbus burst of 4, then one ibus slot
    ibus_req = 1; ibus_addr = 32'h8000_0004;
    dbus_req = 1; dbus_addr = 32'h8000_0008;
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hA5A5_0000;
    got = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      @(negedge clk);
      if (ibus_ready || dbus_ready) begin
        chk($sformatf("order%0d", got), {30'b0, ibus_ready, dbus_ready},
            {30'b0, ~exp_order[got], exp_order[got]});
        got++;
      end
      next_cycle();
    end
    chk("order.count", got, 32'd10);
    idle_inputs();
    next_cycle();

    // Slave never answers: error response 8 cycles into WAIT
    dbus_req = 1; dbus_addr = 32'h0000_0020; dbus_mask = 4'hF;
    mem_gnt = 1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("tout.idle_req", 32'(mem_req), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("tout.req", 32'(mem_req), 32'd1);
    chk("tout.addr", mem_addr, 32'h0000_0020);
    next_cycle();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("tout.wait%0d", k), {30'b0, dbus_ready, mem_req}, 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("tout.ready", 32'(dbus_ready), 32'd1);
    chk("tout.err", 32'(dbus_err), 32'd1);
    chk("tout.rdata", dbus_rdata, 32'd0);
    chk("tout.i_ready", 32'(ibus_ready), 32'd0);
    next_cycle();
    idle_inputs();
    ibus_req = 1; ibus_addr = 32'h8000_0040; ibus_mask = 4'hF; mem_gnt = 1;
    @(negedge clk);
    chk("post_tout.idle", 32'(mem_req), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("post_tout.addr", mem_addr, 32'h0000_0040);
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'h0000_600D;
    @(negedge clk);
    chk("post_tout.ready", 32'(ibus_ready), 32'd1);
    chk("post_tout.err", 32'(ibus_err), 32'd0);
    chk("post_tout.rdata", ibus_rdata, 32'h0000_600D);
    next_cycle();
    idle_inputs();
    next_cycle();

    // Reset while in WAIT, then a late rvalid
    ibus_req = 1; ibus_addr = 32'h0000_0044; mem_gnt = 1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst.in_wait", {30'b0, ibus_ready, mem_req}, 32'd0);
    rst = 1'b0; ibus_req = 0; mem_gnt = 0;
    next_cycle();
    rst = 1'b1; mem_rvalid = 1; mem_rdata = 32'h0000_0077;
    @(negedge clk);
    chk_out("rst.late_rvalid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    mem_rvalid = 0;
    ibus_req = 1; ibus_addr = 32'h0000_0048; mem_gnt = 1;
    @(negedge clk);
    chk_out("rst.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("rst.reissue_req", 32'(mem_req), 32'd1);
    chk("rst.reissue_addr", mem_addr, 32'h0000_0048);
    next_cycle();
    mem_rvalid = 1; mem_rdata = 32'h0000_0099;
    @(negedge clk);
    chk("rst.reissue_ready", 32'(ibus_ready), 32'd1);
    chk("rst.reissue_rdata", ibus_rdata, 32'h0000_0099);
    next_cycle();
    idle_inputs();
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
